// File: rtl/timer_bcd_counter.sv
// MM:SS BCD countdown timer with an internal tick prescaler, button-driven
// setting mode, sticky expiry flag and a combinational all-zero indicator.
module timer_bcd_counter #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       forward,
  input  logic       reset_timer,
  input  logic       seg_demand,
  input  logic       min_demand,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       tick,
  output logic       done,
  output logic       zero
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TC = PW'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_SET   = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_CLEAR = 2'd3
  } mode_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_ones_q, sec_ones_d;
  logic [3:0]    sec_tens_q, sec_tens_d;
  logic [3:0]    min_ones_q, min_ones_d;
  logic [3:0]    min_tens_q, min_tens_d;
  logic          done_q, done_d;
  logic          seg_prev_q, seg_prev_d;
  logic          min_prev_q, min_prev_d;

  mode_e mode;
  logic  seg_press;
  logic  min_press;
  logic  at_tc;
  logic  time_zero;
  logic  tick_c;

  // Priority: synchronous clear beats any enabled activity.
  always_comb begin
    mode = MODE_HOLD;
    if (reset_timer)  mode = MODE_CLEAR;
    else if (enable)  mode = forward ? MODE_SET : MODE_COUNT;
  end

  assign seg_press = seg_demand & ~seg_prev_q;
  assign min_press = min_demand & ~min_prev_q;
  assign at_tc     = (presc_q == TC);
  assign time_zero = (sec_ones_q == 4'd0) && (sec_tens_q == 4'd0) &&
                     (min_ones_q == 4'd0) && (min_tens_q == 4'd0);

  always_comb begin
    presc_d    = presc_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    done_d     = done_q;
    seg_prev_d = seg_demand;
    min_prev_d = min_demand;
    tick_c     = 1'b0;

    case (mode)
      MODE_CLEAR: begin
        presc_d    = '0;
        sec_ones_d = 4'd0;
        sec_tens_d = 4'd0;
        min_ones_d = 4'd0;
        min_tens_d = 4'd0;
        done_d     = 1'b0;
        seg_prev_d = 1'b0;
        min_prev_d = 1'b0;
      end

      MODE_SET: begin
        presc_d = '0;
        done_d  = 1'b0;
        if (seg_press) begin
          if (sec_ones_q == 4'd9) begin
            sec_ones_d = 4'd0;
            sec_tens_d = (sec_tens_q == 4'd5) ? 4'd0 : sec_tens_q + 4'd1;
          end else begin
            sec_ones_d = sec_ones_q + 4'd1;
          end
        end
        if (min_press) begin
          if (min_ones_q == 4'd9) begin
            min_ones_d = 4'd0;
            min_tens_d = (min_tens_q == 4'd9) ? 4'd0 : min_tens_q + 4'd1;
          end else begin
            min_ones_d = min_ones_q + 4'd1;
          end
        end
      end

      MODE_COUNT: begin
        if (at_tc) begin
          presc_d = '0;
          tick_c  = 1'b1;
          if (time_zero) begin
            done_d = 1'b1;
          end else begin
            // One-second decrement with BCD borrow through all four digits.
            if (sec_ones_q != 4'd0) begin
              sec_ones_d = sec_ones_q - 4'd1;
            end else begin
              sec_ones_d = 4'd9;
              if (sec_tens_q != 4'd0) begin
                sec_tens_d = sec_tens_q - 4'd1;
              end else begin
                sec_tens_d = 4'd5;
                if (min_ones_q != 4'd0) begin
                  min_ones_d = min_ones_q - 4'd1;
                end else begin
                  min_ones_d = 4'd9;
                  min_tens_d = min_tens_q - 4'd1;
                end
              end
            end
            if ((sec_ones_d == 4'd0) && (sec_tens_d == 4'd0) &&
                (min_ones_d == 4'd0) && (min_tens_d == 4'd0)) begin
              done_d = 1'b1;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      done_q     <= 1'b0;
      seg_prev_q <= 1'b0;
      min_prev_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      done_q     <= done_d;
      seg_prev_q <= seg_prev_d;
      min_prev_q <= min_prev_d;
    end
  end

  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign min_ones = min_ones_q;
  assign min_tens = min_tens_q;
  assign tick     = tick_c;
  assign done     = done_q;
  assign zero     = time_zero;

endmodule

// File: doc/timer_bcd_counter.md
Name: timer_bcd_counter

Overview:
- Downstream of the timer control state machine; consumes its enableCounter / forward / resetTimer outputs plus the raw seg/min demand buttons.
- Holds the countdown time as four BCD digits (MM:SS) and generates the 1 Hz decrement tick internally.
- Exposes the digits to the VGA digit renderer and flags expiry with a done output.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- TICK_HZ, 1, decrement rate in Hz; prescaler terminal count = CLK_FREQ/TICK_HZ - 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  count/set enable (from enableCounter).
- forward  in  1  1 = setting mode, 0 = countdown mode.
- reset_timer  in  1  synchronous clear (from resetTimer).
- seg_demand  in  1  seconds-set button level, already debounced.
- min_demand  in  1  minutes-set button level, already debounced.
- sec_ones  out  4  BCD seconds units, 0-9.
- sec_tens  out  4  BCD seconds tens, 0-5.
- min_ones  out  4  BCD minutes units, 0-9.
- min_tens  out  4  BCD minutes tens, 0-9.
- tick  out  1  one-cycle pulse at each prescaler terminal count.
- done  out  1  sticky expiry flag.
- zero  out  1  combinational, high when all four digits are 0.

Behaviour:
- Reset (rst high, async): all digits 0, prescaler 0, tick 0, done 0, edge-detect registers 0.
- Priority per cycle: rst > reset_timer > enable.
- reset_timer=1 (sync): same clear as rst, applied on the next edge; overrides enable, forward and buttons in that cycle.
- Edge detect: seg_demand and min_demand are registered each cycle; a press is a rising edge (cur=1, prev=0). Edge registers update regardless of mode, so a button held while entering setting mode does not count.
- Setting mode (enable=1, forward=1):
  - prescaler held at 0; tick=0.
  - seg press: seconds += 1 mod 60 (59 -> 00, no carry into minutes).
  - min press: minutes += 1 mod 100 (99 -> 00).
  - simultaneous presses apply both in the same cycle.
  - done is cleared.
  - digits update on the edge following the press cycle (1-cycle latency).
- Countdown mode (enable=1, forward=0):
  - prescaler increments each cycle; at terminal count it wraps to 0 and tick=1 for that cycle.
  - on tick, if the time is nonzero, decrement by one second with BCD borrow: ss 00 -> 59 and minutes -1; sec_ones 0 -> 9 and sec_tens -1; likewise for minutes.
  - on tick, if the time is already 00:00, no change and done <= 1.
  - the decrement that yields 00:00 also sets done on that same edge.
  - buttons are ignored.
- Hold (enable=0): digits, prescaler and done frozen, so a pause preserves the partial second; tick=0.
- Digits never leave legal BCD ranges; no state reachable from reset produces an illegal digit.
- done stays high until reset_timer, rst, or re-entry into setting mode.

Test Plan:
- Use CLK_FREQ=10, TICK_HZ=1 (tick every 10 cycles).
- Reset: assert rst mid-count at 01:23 -> outputs immediately 00:00, done=0, tick=0; after release, prescaler restarts from 0.
- Setting: enable=1, forward=1; 3 seg presses, 2 min presses, 1 simultaneous press -> digits 03:04. 60 seg presses from 00:00 -> 00:00 with minutes unchanged. 100 min presses -> minutes wrap to 00.
- Countdown borrow: preset 10:00, enable=1, forward=0 -> tick on cycle 10; next digits 09:59. After a further 599 ticks -> 00:00 with done=1 on the same edge; subsequent ticks leave 00:00 and done=1.
- Pause: countdown from 00:05, drop enable after 7 prescaler cycles for 50 cycles, re-enable -> next tick after exactly 3 more cycles; digits 00:04.
- Priority: reset_timer=1 in the same cycle as tick at 00:01 -> 00:00 and done=0 (clear wins). Held seg_demand across a mode entry -> no increment until release and re-press.
